pipeline_elastic_stage: RTL and testbench

PIPELINE_ELASTIC_STAGE -- requirements
Module: pipeline_elastic_stage

---
 rtl/pipeline_elastic_stage.sv | 115 +++++++++++
 tb/tb_pipeline_elastic_stage.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_elastic_stage.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_elastic_stage
//  Description : Two-entry elastic pipeline stage (main + skid register).
//                in_ready comes straight from a flop, so there is no
//                combinational path from out_ready back to in_ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_elastic_stage #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter bit          ZERO_ON_BUBBLE = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            occupancy
);

    // State encoding equals the number of held entries.
    localparam logic [1:0] c_st_empty = 2'd0;
    localparam logic [1:0] c_st_one   = 2'd1;
    localparam logic [1:0] c_st_full  = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic                  r_in_ready;
    logic [DATA_WIDTH-1:0] r_main;
    logic [DATA_WIDTH-1:0] r_skid;
    logic [DATA_WIDTH-1:0] w_main_nxt;
    logic [DATA_WIDTH-1:0] w_skid_nxt;
    logic                  w_out_valid;
    logic                  w_in_fire;
    logic                  w_out_fire;

    assign w_out_valid = (r_state != c_st_empty);
    assign w_in_fire   = in_valid & r_in_ready;
    assign w_out_fire  = w_out_valid & out_ready;

    // State register: state, registered in_ready and both payload registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_st_empty;
            r_in_ready <= 1'b1;
            r_main     <= '0;
            r_skid     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            // Precompute next cycle's ready from the next state.
            r_in_ready <= (w_state_nxt != c_st_full);
            r_main     <= w_main_nxt;
            r_skid     <= w_skid_nxt;
        end
    end

    // Next-state and datapath steering from input/output handshakes.
    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (flush) begin
            // Flush wins: any offered payload is dropped, both registers cleared.
            w_state_nxt = c_st_empty;
            w_main_nxt  = '0;
            w_skid_nxt  = '0;
        end else begin
            case (r_state)
                c_st_empty: begin
                    if (w_in_fire) begin
                        w_state_nxt = c_st_one;
                        w_main_nxt  = in_data;
                    end
                end
                c_st_one: begin
                    if (w_in_fire && !w_out_fire) begin
                        w_state_nxt = c_st_full;
                        w_skid_nxt  = in_data;
                    end else if (w_in_fire && w_out_fire) begin
                        w_main_nxt  = in_data;
                    end else if (w_out_fire) begin
                        w_state_nxt = c_st_empty;
                    end
                end
                c_st_full: begin
                    // in_ready is low here, so only the drain case exists.
                    if (w_out_fire) begin
                        w_state_nxt = c_st_one;
                        w_main_nxt  = r_skid;
                    end
                end
                default: begin
                    w_state_nxt = c_st_empty;
                end
            endcase
        end
    end

    // Output decode: handshake signals, occupancy and bubble masking.
    always_comb begin
        in_ready  = r_in_ready;
        out_valid = w_out_valid;
        occupancy = r_state;
        out_data  = r_main;
        if (ZERO_ON_BUBBLE && !w_out_valid) begin
            out_data = '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_elastic_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_elastic_stage
//  Description : Self-checking bench for pipeline_elastic_stage: vector table,
//                directed reset sequence, random traffic vs. queue model, and
//                two extra instances for the width/bubble parameter sweep.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_elastic_stage;

    typedef struct {
        logic        flush;
        logic        in_valid;
        logic [31:0] in_data;
        logic        out_ready;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic [1:0]  exp_occ;
        logic        exp_ready;
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic [1:0]   occupancy;

    // Sweep instances share the control inputs with the main instance.
    logic [127:0] in_data_w;
    logic [127:0] out_data_w;
    logic         in_ready_w;
    logic         out_valid_w;
    logic [1:0]   occ_w;
    logic [0:0]   in_data_n;
    logic [0:0]   out_data_n;
    logic         in_ready_n;
    logic         out_valid_n;
    logic [1:0]   occ_n;

    int n_tests;
    int n_fail;

    vec_t        vq[$];
    logic [31:0] model[$];

    assign in_data_w = {4{in_data}};
    assign in_data_n = in_data[0];

    pipeline_elastic_stage #(.DATA_WIDTH(32), .ZERO_ON_BUBBLE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy)
    );

    pipeline_elastic_stage #(.DATA_WIDTH(128), .ZERO_ON_BUBBLE(1'b0)) dut_w (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_w), .in_data(in_data_w),
        .out_valid(out_valid_w), .out_ready(out_ready), .out_data(out_data_w),
        .occupancy(occ_w)
    );

    pipeline_elastic_stage #(.DATA_WIDTH(1), .ZERO_ON_BUBBLE(1'b0)) dut_n (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_n), .in_data(in_data_n),
        .out_valid(out_valid_n), .out_ready(out_ready), .out_data(out_data_n),
        .occupancy(occ_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic fl, input logic iv, input logic [31:0] d, input logic ordy,
                           input logic ev, input logic [31:0] ed, input logic [1:0] eo, input logic er);
        vec_t v;
        v.flush = fl; v.in_valid = iv; v.in_data = d; v.out_ready = ordy;
        v.exp_valid = ev; v.exp_data = ed; v.exp_occ = eo; v.exp_ready = er;
        vq.push_back(v);
    endtask

    initial begin
        int iv_bias;
        int or_bias;
        logic fl;
        logic iv;
        logic ordy;
        logic [31:0] d;
        logic fire_in;
        logic fire_out;

        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        out_ready = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) step();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_occupancy", occupancy, 2'd0);
        check("rst_out_data", out_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // ---------------- vector table ----------------
        //       fl iv data          ordy  ev ed            occ  rdy
        // streaming 1,2,3
        add_vec(0, 1, 32'h1,         1,    1, 32'h1,        2'd1, 1);
        add_vec(0, 1, 32'h2,         1,    1, 32'h2,        2'd1, 1);
        add_vec(0, 1, 32'h3,         1,    1, 32'h3,        2'd1, 1);
        add_vec(0, 0, 32'h55,        1,    0, 32'h0,        2'd0, 1);
        // stall and fill, then drain in order
        add_vec(0, 1, 32'hA,         0,    1, 32'hA,        2'd1, 1);
        add_vec(0, 1, 32'hB,         0,    1, 32'hA,        2'd2, 0);
        add_vec(0, 1, 32'hC,         0,    1, 32'hA,        2'd2, 0);
        add_vec(0, 0, 32'h0,         1,    1, 32'hB,        2'd1, 1);
        add_vec(0, 0, 32'h0,         1,    0, 32'h0,        2'd0, 1);
        // flush while full with a payload offered
        add_vec(0, 1, 32'hA,         0,    1, 32'hA,        2'd1, 1);
        add_vec(0, 1, 32'hB,         0,    1, 32'hA,        2'd2, 0);
        add_vec(1, 1, 32'hC,         0,    0, 32'h0,        2'd0, 1);
        add_vec(0, 0, 32'h0,         1,    0, 32'h0,        2'd0, 1);
        // flush while ONE, with output fire and offered payload
        add_vec(0, 1, 32'hD,         0,    1, 32'hD,        2'd1, 1);
        add_vec(1, 1, 32'hE,         1,    0, 32'h0,        2'd0, 1);
        add_vec(0, 0, 32'h0,         1,    0, 32'h0,        2'd0, 1);

        foreach (vq[i]) begin
            flush     = vq[i].flush;
            in_valid  = vq[i].in_valid;
            in_data   = vq[i].in_data;
            out_ready = vq[i].out_ready;
            step();
            check($sformatf("vec%0d_out_valid", i), out_valid, vq[i].exp_valid);
            check($sformatf("vec%0d_out_data", i), out_data, vq[i].exp_data);
            check($sformatf("vec%0d_occupancy", i), occupancy, vq[i].exp_occ);
            check($sformatf("vec%0d_in_ready", i), in_ready, vq[i].exp_ready);
            check($sformatf("vec%0d_w128_occ", i), occ_w, vq[i].exp_occ);
            check($sformatf("vec%0d_w128_ready", i), in_ready_w, vq[i].exp_ready);
            check($sformatf("vec%0d_w1_occ", i), occ_n, vq[i].exp_occ);
            check($sformatf("vec%0d_w1_ready", i), in_ready_n, vq[i].exp_ready);
            if (vq[i].exp_valid) begin
                check($sformatf("vec%0d_w128_data", i), out_data_w, {4{vq[i].exp_data}});
                check($sformatf("vec%0d_w1_data", i), out_data_n, vq[i].exp_data[0]);
            end
        end
        flush = 1'b0;

        // ---------------- asynchronous reset while FULL ----------------
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h11;
        step();
        in_data   = 32'h22;
        step();
        in_valid  = 1'b0;
        check("arst_pre_occ", occupancy, 2'd2);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_in_ready", in_ready, 1'b1);
        check("arst_occupancy", occupancy, 2'd0);
        check("arst_out_data", out_data, 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        check("arst_post_valid", out_valid, 1'b0);
        check("arst_post_occ", occupancy, 2'd0);
        in_valid = 1'b1;
        in_data  = 32'h77;
        step();
        in_valid = 1'b0;
        check("arst_resume_valid", out_valid, 1'b1);
        check("arst_resume_data", out_data, 32'h77);
        step();
        check("arst_resume_drain", occupancy, 2'd0);

        // ---------------- random traffic vs. queue model ----------------
        model.delete();
        iv_bias = 50;
        or_bias = 50;
        for (int c = 0; c < 10000; c++) begin
            check("rnd_out_valid", out_valid, model.size() != 0);
            check("rnd_occupancy", occupancy, 128'(model.size()));
            check("rnd_in_ready", in_ready, model.size() < 2);
            check("rnd_out_data", out_data, (model.size() != 0) ? model[0] : 32'h0);
            if (c % 500 == 0) begin
                iv_bias = $urandom_range(10, 95);
                or_bias = $urandom_range(10, 95);
            end
            fl   = ($urandom_range(0, 99) == 0);
            iv   = ($urandom_range(0, 99) < iv_bias);
            ordy = ($urandom_range(0, 99) < or_bias);
            d    = $urandom;
            flush     = fl;
            in_valid  = iv;
            out_ready = ordy;
            in_data   = d;
            fire_in  = iv && (model.size() < 2);
            fire_out = ordy && (model.size() != 0);
            if (fl) begin
                model.delete();
            end else begin
                if (fire_out) void'(model.pop_front());
                if (fire_in) model.push_back(d);
            end
            step();
        end
        flush    = 1'b0;
        in_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
